intel_fpga_sram_lanes: RTL and testbench
========================================

# intel_fpga_sram_lanes

Single-clock, true-dual-port inferred SRAM for Intel FPGAs. It accepts any `WIDTH` with a per-byte write mask, built as an array of independent byte-lane memories. It adds three things the fixed-width 32/64-bit variants lack:
- a hardware clear-on-reset sequencer;
- per-port read-valid tracking;
- optional read-during-write forwarding.

It is the general replacement for the fixed-width wbmask variants in LETC cache and scratchpad arrays.

## Interface
Parameters:
- `DEPTH`, 1024: entries; power of 2, ≥ 2.
- `WIDTH`, 32: data bits, ≥ 1. Lane count `LANES = ceil(WIDTH/8)`; the top lane may be partial.
- `OUTPUT_REGISTER`, 0: if 1, adds an output flop stage.
- `CLEAR_ON_RESET`, 1: if 1, zeroes every entry after reset.

Ports (`[1:0]` is indexed by port `p`):
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `busy`, output, 1: high while the clear sequence runs; requests are ignored.
- `addr`, input, `[1:0][ADDR_WIDTH-1:0]`: per-port address. `ADDR_WIDTH = $clog2(DEPTH)`.
- `re`, input, `[1:0]`: read enable.
- `rvalid`, output, `[1:0]`: `rdata[p]` holds the result of an accepted read.
- `rdata`, output, `[1:0][WIDTH-1:0]`: read data.
- `we`, input, `[1:0]`: write enable.
- `wdata`, input, `[1:0][WIDTH-1:0]`: write data.
- `wbmask`, input, `[1:0][LANES-1:0]`: byte write mask. Bit `j` covers `wdata[p][8j +: 8]`, truncated for the partial top lane.

## Operation
- A request is accepted on port `p` when `!busy` and `re[p]` or `we[p]` is high. While `busy` is high, all `re`/`we` are ignored and no `rvalid` is produced.
- Writes update only the lanes whose `wbmask[p][j]` is 1. `we` with an all-zero mask is a no-op.
- A read on the same port as a simultaneous write returns the old data.
- When `re[p]` is 0, `rdata[p]` holds its last value.
- Cross-port simultaneous writes to the same address with overlapping mask bits leave the affected bytes undefined.
- Clear FSM states:
  - `CLEAR`: entered on reset when `CLEAR_ON_RESET=1`. Each cycle, port 0 writes all-zero to `clr_addr` with all lanes enabled, then `clr_addr` increments. After writing address `DEPTH-1`, go to `READY`.
  - `READY`: normal operation; terminal state.
  - With `CLEAR_ON_RESET=0`, reset enters `READY` directly and contents are unspecified.
- Reset asserted mid-clear: `clr_addr` returns to 0 and the sequence restarts from scratch after release.
- Reset values: `busy = CLEAR_ON_RESET`, `rvalid = 2'b00`, `clr_addr = 0`.
  - `rdata` is don't-care while `rvalid[p]` is 0.
  - The optional output stage flops reset to 0.
  - Memory contents are not reset by `rst_n`; only the clear FSM touches them.

## Timing
- Read latency `L = 1 + OUTPUT_REGISTER`: `re[p]` accepted at edge `n` gives `rdata[p]`/`rvalid[p]` valid after edge `n+L`.
- `rvalid[p]` is a single-cycle pulse per accepted read. Back-to-back reads give a continuous `rvalid` with a new word every cycle.
- Write-to-read: a write at edge `n` is visible to a read accepted at edge `n+1` on either port.
- Clear duration: `busy` falls exactly `DEPTH` cycles after the first rising edge with `rst_n` high. A request in the first cycle with `busy` low is accepted.

## Configuration
- `LETC_SRAM_RDW_FORWARD_EN` defined:
  - A read accepted on port `p` in the same cycle as a write by the other port to the same address returns the new bytes for the lanes in that port's `wbmask`, and old bytes elsewhere.
  - Implemented by registering a per-lane forward select plus `wdata`, and muxing after the RAM output. This adds no latency.
- Macro undefined: the cross-port same-cycle read returns old data for all lanes, with no forwarding logic.
- Same-port behaviour is old data in both cases.

## Structure
- Package `letc_sram_pkg`:
  - `sram_clear_state_e` (`CLEAR`, `READY`);
  - function `sram_lanes(width)` returning `ceil(width/8)`.
- Sub-module `intel_fpga_sram_lane`: an 8-bit (or narrower, via parameter `LANE_WIDTH`) dual-port RAM with separate port-0/port-1 `always_ff` blocks, written out explicitly rather than looped, so Quartus infers M9K/M10K.
- The top level generate-instantiates `LANES` lanes. It contains the clear FSM, the write-enable/mask muxing (clear overrides port 0), the `rvalid` shift stages, the optional output register and the forwarding mux.

## Test plan
- Reset with `DEPTH=16`, `CLEAR_ON_RESET=1`: `busy` high for exactly 16 cycles. Then reads of addresses 0..15 all return 0 with `rvalid` one pulse per read.
- `WIDTH=20` (`LANES=3`): write `20'hABCDE` at addr 5 with mask `3'b111`, then `20'h12345` with mask `3'b010`. Reading addr 5 returns `20'hA23DE`.
- Same-port write `0x11111111` and read at addr 3, where the old value is `0xDEADBEEF`: the read returns `0xDEADBEEF`. The next read returns `0x11111111`.
- Port 1 writes `0xCAFEF00D` with mask `4'b0011` to addr 7 (old `0x00000000`) while port 0 reads addr 7. Expected return:
  - `0x0000F00D` with `LETC_SRAM_RDW_FORWARD_EN`;
  - `0x00000000` without it.
- `OUTPUT_REGISTER=1`: reads accepted on 4 consecutive cycles give `rvalid` high for 4 consecutive cycles, starting 2 edges after the first read, with data in order.
- Assert `rst_n` when `clr_addr=9` during a `DEPTH=16` clear, then release. `busy` stays high a full 16 cycles and every address reads 0.

Source files
------------

// File: rtl/intel_fpga_sram_lanes_pkg.sv
// Shared types and helpers for the byte-lane true-dual-port SRAM.
package letc_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_clear_state_e;

    function automatic int sram_lanes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/intel_fpga_sram_lanes_if.sv
// Dual-port request/response bundle for intel_fpga_sram_lanes; [1:0] indexes the port.
interface intel_fpga_sram_lanes_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LANES      = letc_sram_pkg::sram_lanes(WIDTH);

    logic                        busy;
    logic [1:0][ADDR_WIDTH-1:0]  addr;
    logic [1:0]                  re;
    logic [1:0]                  we;
    logic [1:0][WIDTH-1:0]       wdata;
    logic [1:0][LANES-1:0]       wbmask;
    logic [1:0]                  rvalid;
    logic [1:0][WIDTH-1:0]       rdata;

    modport master (
        input  busy, rvalid, rdata,
        output addr, re, we, wdata, wbmask
    );

    modport slave (
        output busy, rvalid, rdata,
        input  addr, re, we, wdata, wbmask
    );
endinterface

// File: rtl/intel_fpga_sram_lane.sv
// One byte (or narrower) lane: dual-port RAM with one always_ff per port so block RAM is inferred.
module intel_fpga_sram_lane #(
    parameter  int DEPTH      = 1024,
    parameter  int LANE_WIDTH = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr0,
    input  logic [AW-1:0]         addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  re0,
    input  logic                  re1,
    input  logic [LANE_WIDTH-1:0] wdata0,
    input  logic [LANE_WIDTH-1:0] wdata1,
    output logic [LANE_WIDTH-1:0] rdata0,
    output logic [LANE_WIDTH-1:0] rdata1
);
    logic [LANE_WIDTH-1:0] mem [DEPTH];
    logic [LANE_WIDTH-1:0] rdata0_q;
    logic [LANE_WIDTH-1:0] rdata1_q;

    // Read-before-write on each port; output holds while re is low.
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= wdata0;
        if (re0) rdata0_q <= mem[addr0];
    end

    always_ff @(posedge clk) begin
        if (we1) mem[addr1] <= wdata1;
        if (re1) rdata1_q <= mem[addr1];
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
endmodule

// File: rtl/intel_fpga_sram_lanes.sv
// Byte-masked true-dual-port SRAM with clear-on-reset, read-valid tracking and optional output stage.
// Define LETC_SRAM_RDW_FORWARD_EN to forward cross-port same-cycle write bytes into reads.
module intel_fpga_sram_lanes #(
    parameter int DEPTH           = 1024,
    parameter int WIDTH           = 32,
    parameter int OUTPUT_REGISTER = 0,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    intel_fpga_sram_lanes_if.slave  bus
);
    import letc_sram_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = sram_lanes(WIDTH);
    localparam int L     = 1 + OUTPUT_REGISTER;
    localparam sram_clear_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    sram_clear_state_e state_q, state_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              busy;
    logic [1:0]        acc_re, acc_we;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == AW'(DEPTH - 1)) state_d = READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign bus.busy = busy;
    assign acc_re   = bus.re & {2{~busy}};
    assign acc_we   = bus.we & {2{~busy}};

    logic [1:0][WIDTH-1:0] ram_rd, rd_raw;

    // The clear sequencer borrows port 0 with every lane enabled.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int LO = 8 * j;
        localparam int LW = (WIDTH - LO < 8) ? (WIDTH - LO) : 8;
        logic          we0, we1;
        logic [AW-1:0] a0;
        logic [LW-1:0] wd0;

        assign we0 = busy | (acc_we[0] & bus.wbmask[0][j]);
        assign we1 = acc_we[1] & bus.wbmask[1][j];
        assign a0  = busy ? clr_addr_q : bus.addr[0];
        assign wd0 = busy ? '0 : bus.wdata[0][LO +: LW];

        intel_fpga_sram_lane #(.DEPTH(DEPTH), .LANE_WIDTH(LW)) u_lane (
            .clk    (clk),
            .addr0  (a0),
            .addr1  (bus.addr[1]),
            .we0    (we0),
            .we1    (we1),
            .re0    (acc_re[0]),
            .re1    (acc_re[1]),
            .wdata0 (wd0),
            .wdata1 (bus.wdata[1][LO +: LW]),
            .rdata0 (ram_rd[0][LO +: LW]),
            .rdata1 (ram_rd[1][LO +: LW])
        );
    end

`ifdef LETC_SRAM_RDW_FORWARD_EN
    logic [1:0][LANES-1:0] fwd_sel_q, fwd_sel_d;
    logic [1:0][WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Captured only with an accepted read so the muxed result holds alongside the RAM output.
    always_comb begin
        fwd_sel_d  = fwd_sel_q;
        fwd_data_d = fwd_data_q;
        for (int p = 0; p < 2; p++) begin
            if (acc_re[p]) begin
                fwd_sel_d[p]  = (acc_we[1-p] && (bus.addr[1-p] == bus.addr[p])) ? bus.wbmask[1-p] : '0;
                fwd_data_d[p] = bus.wdata[1-p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_q  <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_fwd_port
        for (genvar j = 0; j < LANES; j++) begin : g_fwd_lane
            localparam int LO = 8 * j;
            localparam int LW = (WIDTH - LO < 8) ? (WIDTH - LO) : 8;
            assign rd_raw[p][LO +: LW] = fwd_sel_q[p][j] ? fwd_data_q[p][LO +: LW] : ram_rd[p][LO +: LW];
        end
    end
`else
    assign rd_raw = ram_rd;
`endif

    logic [L-1:0][1:0] vld_q, vld_d;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = acc_re;
        for (int i = 1; i < L; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign bus.rvalid = vld_q[L-1];

    if (OUTPUT_REGISTER != 0) begin : g_oreg
        logic [1:0][WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            for (int p = 0; p < 2; p++)
                if (vld_q[0][p]) rdata_d[p] = rd_raw[p];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rdata_q <= '0;
            else        rdata_q <= rdata_d;
        end

        assign bus.rdata = rdata_q;
    end else begin : g_noreg
        assign bus.rdata = rd_raw;
    end
endmodule

// File: tb/tb_intel_fpga_sram_lanes.sv
// Bench for intel_fpga_sram_lanes: 32-bit/L=1 and 20-bit/L=2 instances driven in lockstep.
module tb_intel_fpga_sram_lanes;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intel_fpga_sram_lanes_if #(.DEPTH(DEPTH), .WIDTH(32)) bus_a ();
    intel_fpga_sram_lanes_if #(.DEPTH(DEPTH), .WIDTH(20)) bus_b ();

    intel_fpga_sram_lanes #(.DEPTH(DEPTH), .WIDTH(32), .OUTPUT_REGISTER(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    intel_fpga_sram_lanes #(.DEPTH(DEPTH), .WIDTH(20), .OUTPUT_REGISTER(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [1:0]       s_re, s_we;
    logic [1:0][3:0]  s_addr, s_m;
    logic [1:0][31:0] s_wd;

    assign bus_a.re     = s_re;
    assign bus_a.we     = s_we;
    assign bus_a.addr   = s_addr;
    assign bus_a.wdata  = s_wd;
    assign bus_a.wbmask = s_m;
    assign bus_b.re     = s_re;
    assign bus_b.we     = s_we;
    assign bus_b.addr   = s_addr;
    assign bus_b.wdata  = {s_wd[1][19:0], s_wd[0][19:0]};
    assign bus_b.wbmask = {s_m[1][2:0], s_m[0][2:0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    // Reference model: plain word arrays plus per-port queues of {due cycle, word}.
    typedef struct { int due; logic [31:0] d; } exp_t;
    exp_t q_a0[$], q_a1[$], q_b0[$], q_b1[$];
    logic [31:0] mem_a [DEPTH];
    logic [19:0] mem_b [DEPTH];
    bit model_busy = 1'b1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) if (m[j]) r[8*j +: 8] = nw[8*j +: 8];
        return r;
    endfunction

    task automatic model(input int k);
        logic [31:0] ra, rb, t;
        if (model_busy) return;
        for (int p = 0; p < 2; p++) begin
            if (s_re[p]) begin
                ra = mem_a[s_addr[p]];
                rb = {12'b0, mem_b[s_addr[p]]};
`ifdef LETC_SRAM_RDW_FORWARD_EN
                if (s_we[1-p] && s_addr[1-p] == s_addr[p]) begin
                    ra = merge(ra, s_wd[1-p], s_m[1-p]);
                    rb = merge(rb, s_wd[1-p], {1'b0, s_m[1-p][2:0]}) & 32'h000F_FFFF;
                end
`endif
                if (p == 0) begin q_a0.push_back('{k, ra}); q_b0.push_back('{k + 1, rb}); end
                else        begin q_a1.push_back('{k, ra}); q_b1.push_back('{k + 1, rb}); end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (s_we[p]) begin
                mem_a[s_addr[p]] = merge(mem_a[s_addr[p]], s_wd[p], s_m[p]);
                t = merge({12'b0, mem_b[s_addr[p]]}, s_wd[p], {1'b0, s_m[p][2:0]});
                mem_b[s_addr[p]] = t[19:0];
            end
        end
    endtask

    task automatic step();
        int k;
        k = cyc + 1;
        model(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_re = '0; s_we = '0; s_addr = '0; s_wd = '0; s_m = '0;
    endtask

    task automatic rand_req();
        s_re = 2'($urandom); s_we = 2'($urandom);
        s_addr[0] = 4'($urandom_range(0, 3)); s_addr[1] = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) s_addr[1] = 4'($urandom);
        s_wd[0] = $urandom; s_wd[1] = $urandom;
        s_m[0] = 4'($urandom); s_m[1] = 4'($urandom);
        if (s_we == 2'b11 && s_addr[0] == s_addr[1]) s_we[1] = 1'b0;
    endtask

    task automatic cmp(input string nm, input logic [39:0] act, input logic [39:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk(input string nm, input logic v, input logic [31:0] d, input bit has, input logic [31:0] e);
        vectors++;
        if (v !== has) begin
            errors++;
            $display("FAIL %s rvalid: got %b, expected %b (cycle %0d)", nm, v, has, cyc);
        end else if (has && d !== e) begin
            errors++;
            $display("FAIL %s rdata: got %h, expected %h (cycle %0d)", nm, d, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit h;
        h = (q_a0.size() > 0) && (q_a0[0].due == cyc);
        chk("rd_a_p0", bus_a.rvalid[0], bus_a.rdata[0], h, h ? q_a0[0].d : 32'h0);
        if (h) void'(q_a0.pop_front());
        h = (q_a1.size() > 0) && (q_a1[0].due == cyc);
        chk("rd_a_p1", bus_a.rvalid[1], bus_a.rdata[1], h, h ? q_a1[0].d : 32'h0);
        if (h) void'(q_a1.pop_front());
        h = (q_b0.size() > 0) && (q_b0[0].due == cyc);
        chk("rd_b_p0", bus_b.rvalid[0], {12'b0, bus_b.rdata[0]}, h, h ? q_b0[0].d : 32'h0);
        if (h) void'(q_b0.pop_front());
        h = (q_b1.size() > 0) && (q_b1[0].due == cyc);
        chk("rd_b_p1", bus_b.rvalid[1], {12'b0, bus_b.rdata[1]}, h, h ? q_b1[0].d : 32'h0);
        if (h) void'(q_b1.pop_front());
    end

    // Requests are driven while busy to confirm they are ignored; a full clear zeroes the model.
    task automatic count_busy(input string nm);
        int na, nb, n;
        na = 0; nb = 0; n = 0;
        while ((bus_a.busy || bus_b.busy) && n < 64) begin
            if (bus_a.busy) na++;
            if (bus_b.busy) nb++;
            rand_req();
            step();
            n++;
        end
        idle();
        cmp({nm, "_a"}, 40'(na), 40'(DEPTH));
        cmp({nm, "_b"}, 40'(nb), 40'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        model_busy = 1'b0;
    endtask

    task automatic assert_reset();
        model_busy = 1'b1;
        idle();
        rst_n = 1'b0;
        q_a0.delete(); q_a1.delete(); q_b0.delete(); q_b1.delete();
        step();
        cmp("reset_busy", {38'b0, bus_b.busy, bus_a.busy}, 40'h3);
        cmp("reset_rvalid", {36'b0, bus_b.rvalid, bus_a.rvalid}, 40'h0);
        cmp("reset_oreg", {bus_b.rdata}, 40'h0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            s_re = 2'b11; s_we = 2'b00;
            s_addr[0] = 4'(a); s_addr[1] = 4'(DEPTH - 1 - a);
            step();
        end
        idle();
        repeat (3) step();
    endtask

    typedef struct {
        logic [1:0]  re, we;
        logic [3:0]  a0, a1;
        logic [31:0] wd0, wd1;
        logic [3:0]  m0, m1;
        bit          check;
        logic [31:0] ea;
        logic [19:0] eb;
    } vec_t;
    vec_t tbl[8];

`ifdef LETC_SRAM_RDW_FORWARD_EN
    localparam logic [31:0] XA = 32'h0000_F00D;
    localparam logic [19:0] XB = 20'h0F00D;
`else
    localparam logic [31:0] XA = 32'h0;
    localparam logic [19:0] XB = 20'h0;
`endif

    initial begin
        bit exp_v[6];
        tbl[0] = '{2'b00, 2'b01, 4'd5, 4'd0, 32'h000A_BCDE, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 20'h0};
        tbl[1] = '{2'b00, 2'b01, 4'd5, 4'd0, 32'h0001_2345, 32'h0, 4'h2, 4'h0, 1'b0, 32'h0, 20'h0};
        tbl[2] = '{2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 32'h000A_23DE, 20'hA23DE};
        tbl[3] = '{2'b00, 2'b01, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 20'h0};
        tbl[4] = '{2'b01, 2'b01, 4'd3, 4'd0, 32'h1111_1111, 32'h0, 4'hF, 4'h0, 1'b1, 32'hDEAD_BEEF, 20'hDBEEF};
        tbl[5] = '{2'b01, 2'b00, 4'd3, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 32'h1111_1111, 20'h11111};
        tbl[6] = '{2'b01, 2'b10, 4'd7, 4'd7, 32'h0, 32'hCAFE_F00D, 4'h0, 4'h3, 1'b1, XA, XB};
        tbl[7] = '{2'b01, 2'b00, 4'd7, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 32'h0000_F00D, 20'h0F00D};

        idle();
        assert_reset();
        step();
        rst_n = 1'b1;
        count_busy("clear_cycles");
        read_all();

        for (int i = 0; i < 8; i++) begin
            s_re = tbl[i].re; s_we = tbl[i].we;
            s_addr[0] = tbl[i].a0; s_addr[1] = tbl[i].a1;
            s_wd[0] = tbl[i].wd0; s_wd[1] = tbl[i].wd1;
            s_m[0] = tbl[i].m0; s_m[1] = tbl[i].m1;
            step();
            idle();
            step();
            if (tbl[i].check) begin
                cmp($sformatf("table%0d_a", i), {8'b0, bus_a.rdata[0]}, {8'b0, tbl[i].ea});
                cmp($sformatf("table%0d_b", i), {20'b0, bus_b.rdata[0]}, {20'b0, tbl[i].eb});
            end
        end

        repeat (400) begin
            rand_req();
            step();
        end
        idle();
        repeat (3) step();

        // Four back-to-back reads through the output-register instance.
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin s_re = 2'b01; s_addr[0] = 4'(8 + i); end
            else idle();
            step();
            cmp($sformatf("burst_rvalid%0d", i), {39'b0, bus_b.rvalid[0]}, {39'b0, exp_v[i]});
        end
        idle();
        repeat (3) step();

        // Reset partway through a clear restarts it from address 0.
        assert_reset();
        rst_n = 1'b1;
        repeat (9) begin rand_req(); step(); end
        assert_reset();
        rst_n = 1'b1;
        count_busy("reclear_cycles");
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
